// File: rtl/mux_pkg.sv
// Shared constants for the 16:1 multiplexer.
//   MUX16_N     : number of candidate inputs
//   MUX16_SEL_W : width of the select index
package mux_pkg;

  localparam int unsigned MUX16_N     = 16;
  localparam int unsigned MUX16_SEL_W = 4;

endpackage

// File: rtl/mux2_1.sv
// 2:1 multiplexer leaf cell used to build the 16:1 tree.
// Ports:
//   data1_in : selected when sel = 1
//   data2_in : selected when sel = 0
//   sel      : select
//   data_out : selected bit
module mux2_1
  import mux_pkg::*;
(
  input  logic data1_in,
  input  logic data2_in,
  input  logic sel,
  output logic data_out
);

  assign data_out = sel ? data1_in : data2_in;

endmodule

// File: rtl/mux16_1.sv
// 16:1 bit multiplexer built as a balanced tree of mux2_1 cells, with an optional
// enable-loaded output register.
// Parameters:
//   REG_OUT    : 1 builds the output register, 0 ties data_out_q to data_out
// Ports:
//   clk        : clock, rising edge
//   reset_n    : asynchronous active-low reset of data_out_q
//   data_in    : candidate bits, index i is input i
//   sel        : index of the selected input
//   en         : load enable for data_out_q
//   data_out   : combinational data_in[sel]
//   data_out_q : registered copy of data_out
module mux16_1
  import mux_pkg::*;
#(
  parameter bit REG_OUT = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [MUX16_N-1:0]     data_in,
  input  logic [MUX16_SEL_W-1:0] sel,
  input  logic                   en,
  output logic                   data_out,
  output logic                   data_out_q
);

  // Tree levels: level k resolves sel[k]; the odd (higher-index) child goes to data1_in.
  logic [7:0] lvl0;
  logic [3:0] lvl1;
  logic [1:0] lvl2;
  logic       lvl3;

  for (genvar j = 0; j < 8; j++) begin : g_lvl0
    mux2_1 u_mux (
      .data1_in (data_in[2*j+1]),
      .data2_in (data_in[2*j]),
      .sel      (sel[0]),
      .data_out (lvl0[j])
    );
  end

  for (genvar j = 0; j < 4; j++) begin : g_lvl1
    mux2_1 u_mux (
      .data1_in (lvl0[2*j+1]),
      .data2_in (lvl0[2*j]),
      .sel      (sel[1]),
      .data_out (lvl1[j])
    );
  end

  for (genvar j = 0; j < 2; j++) begin : g_lvl2
    mux2_1 u_mux (
      .data1_in (lvl1[2*j+1]),
      .data2_in (lvl1[2*j]),
      .sel      (sel[2]),
      .data_out (lvl2[j])
    );
  end

  mux2_1 u_root (
    .data1_in (lvl2[1]),
    .data2_in (lvl2[0]),
    .sel      (sel[3]),
    .data_out (lvl3)
  );

  assign data_out = lvl3;

  if (REG_OUT) begin : g_reg
    logic out_d, out_q;

    always_comb begin
      out_d = out_q;
      if (en) begin
        out_d = data_out;
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        out_q <= 1'b0;
      end else begin
        out_q <= out_d;
      end
    end

    assign data_out_q = out_q;
  end else begin : g_noreg
    assign data_out_q = data_out;
  end

endmodule

// File: tb/tb_mux16_1.sv
// Self-checking bench for mux16_1 (registered and unregistered builds) and the mux2_1 cell.
module tb_mux16_1;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] data_in;
  logic [3:0]  sel;
  logic        en;
  logic        data_out, data_out_q;
  logic        c_out, c_out_q;
  logic        u_d1, u_d2, u_sel, u_out;

  int pass_cnt  = 0;
  int total_cnt = 0;

  typedef enum int {ObsOut, ObsQ, ObsCombQ, ObsUnit} obs_e;
  typedef struct {
    string tag;
    obs_e  which;
    logic  exp;
  } sb_t;

  sb_t sb_q[$];

  always #5 clk = ~clk;

  mux16_1 #(.REG_OUT(1'b1)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .data_in    (data_in),
    .sel        (sel),
    .en         (en),
    .data_out   (data_out),
    .data_out_q (data_out_q)
  );

  mux16_1 #(.REG_OUT(1'b0)) dut_comb (
    .clk        (clk),
    .reset_n    (reset_n),
    .data_in    (data_in),
    .sel        (sel),
    .en         (en),
    .data_out   (c_out),
    .data_out_q (c_out_q)
  );

  mux2_1 u_cell (
    .data1_in (u_d1),
    .data2_in (u_d2),
    .sel      (u_sel),
    .data_out (u_out)
  );

  function automatic void expect_val(input string tag, input obs_e which, input logic exp);
    sb_t e;
    e.tag   = tag;
    e.which = which;
    e.exp   = exp;
    sb_q.push_back(e);
  endfunction

  // Pop every pending expectation and compare against the DUT now.
  task automatic check_pending();
    sb_t  e;
    logic obs;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      case (e.which)
        ObsOut:   obs = data_out;
        ObsQ:     obs = data_out_q;
        ObsCombQ: obs = c_out_q;
        default:  obs = u_out;
      endcase
      total_cnt++;
      assert (obs === e.exp) pass_cnt++;
      else $error("FAIL %s: observed %b expected %b", e.tag, obs, e.exp);
    end
  endtask

  initial begin
    logic [15:0] pat;

    // Reset held low: register cleared regardless of clock and enable.
    reset_n = 1'b0;
    en      = 1'b1;
    data_in = 16'hffff;
    sel     = 4'd5;
    u_d1 = 1'b0; u_d2 = 1'b0; u_sel = 1'b0;
    #1;
    expect_val("reset_q", ObsQ, 1'b0);
    expect_val("reset_out", ObsOut, 1'b1);
    expect_val("reset_comb_q", ObsCombQ, 1'b1);
    check_pending();
    @(posedge clk); #1;
    expect_val("reset_q_after_edge", ObsQ, 1'b0);
    check_pending();

    @(negedge clk);
    reset_n = 1'b1;
    en      = 1'b0;

    // Directed corner selections.
    data_in = 16'h0001; sel = 4'd0;  #1; expect_val("h0001_sel0", ObsOut, 1'b1); check_pending();
    sel = 4'd15; #1; expect_val("h0001_sel15", ObsOut, 1'b0); check_pending();
    data_in = 16'h8000; sel = 4'd15; #1; expect_val("h8000_sel15", ObsOut, 1'b1); check_pending();
    sel = 4'd14; #1; expect_val("h8000_sel14", ObsOut, 1'b0); check_pending();
    sel = 4'd8;  #1; expect_val("h8000_sel8", ObsOut, 1'b0); check_pending();
    data_in = 16'h0100; #1; expect_val("h0100_sel8", ObsOut, 1'b1); check_pending();

    // Walking one and walking zero over every position and every select.
    for (int p = 0; p < 16; p++) begin
      for (int s = 0; s < 16; s++) begin
        pat     = 16'h0001 << p;
        data_in = pat;
        sel     = 4'(s);
        #1;
        expect_val($sformatf("walk1_p%0d_s%0d", p, s), ObsOut, (p == s));
        expect_val($sformatf("walk1_comb_p%0d_s%0d", p, s), ObsCombQ, (p == s));
        check_pending();
      end
    end
    for (int p = 0; p < 16; p++) begin
      for (int s = 0; s < 16; s++) begin
        pat     = ~(16'h0001 << p);
        data_in = pat;
        sel     = 4'(s);
        #1;
        expect_val($sformatf("walk0_p%0d_s%0d", p, s), ObsOut, (p != s));
        check_pending();
      end
    end

    // Register: one-cycle load latency and hold with en low.
    @(negedge clk);
    en = 1'b1; data_in = 16'h0004; sel = 4'd2;
    #1;
    expect_val("load_out_now", ObsOut, 1'b1);
    expect_val("load_q_before_edge", ObsQ, 1'b0);
    check_pending();
    @(posedge clk); #1;
    expect_val("load_q_after_edge", ObsQ, 1'b1);
    check_pending();
    @(negedge clk);
    en = 1'b0; sel = 4'd3;
    #1;
    expect_val("hold_out", ObsOut, 1'b0);
    check_pending();
    @(posedge clk); #1;
    expect_val("hold_q", ObsQ, 1'b1);
    check_pending();
    @(negedge clk);
    en = 1'b1;
    @(posedge clk); #1;
    expect_val("load_zero_q", ObsQ, 1'b0);
    check_pending();
    @(negedge clk);
    sel = 4'd2;
    @(posedge clk); #1;
    expect_val("reload_q", ObsQ, 1'b1);
    check_pending();

    // Asynchronous reset between edges; combinational path keeps working.
    reset_n = 1'b0;
    #1;
    expect_val("async_reset_q", ObsQ, 1'b0);
    expect_val("async_reset_out", ObsOut, 1'b1);
    check_pending();
    data_in = 16'h0000; #1;
    expect_val("reset_track_out0", ObsOut, 1'b0);
    check_pending();
    data_in = 16'h0004; #1;
    expect_val("reset_track_out1", ObsOut, 1'b1);
    check_pending();
    @(posedge clk); #1;
    expect_val("reset_hold_q", ObsQ, 1'b0);
    check_pending();
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    expect_val("release_q_no_edge", ObsQ, 1'b0);
    check_pending();
    @(posedge clk); #1;
    expect_val("release_first_load", ObsQ, 1'b1);
    check_pending();

    // mux2_1 cell.
    u_sel = 1'b1; u_d1 = 1'b1; u_d2 = 1'b0; #1; expect_val("cell_sel1", ObsUnit, 1'b1); check_pending();
    u_sel = 1'b0; #1; expect_val("cell_sel0", ObsUnit, 1'b0); check_pending();
    u_d1 = 1'b0; u_d2 = 1'b1; #1; expect_val("cell_sel0_d2", ObsUnit, 1'b1); check_pending();
    u_sel = 1'b1; #1; expect_val("cell_sel1_d1", ObsUnit, 1'b0); check_pending();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
